// File: rtl/fixed_linear_requant_pack.sv
// Requantises wide signed accumulator lanes (round half up, saturate, optional ReLU) and
// packs PACK consecutive input beats into one output beat; one input beat per cycle.
module fixed_linear_requant_pack #(
  parameter int IN_WIDTH       = 56,
  parameter int IN_FRAC_WIDTH  = 0,
  parameter int IN_SIZE        = 2,
  parameter int OUT_WIDTH      = 8,
  parameter int OUT_FRAC_WIDTH = 0,
  parameter int PACK           = 2,
  parameter int OUT_SIZE       = IN_SIZE * PACK,
  parameter int HAS_RELU       = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [IN_SIZE-1:0][IN_WIDTH-1:0]     data_in,
  input  logic                                 data_in_valid,
  output logic                                 data_in_ready,
  output logic [OUT_SIZE-1:0][OUT_WIDTH-1:0]   data_out,
  output logic                                 data_out_valid,
  input  logic                                 data_out_ready
);

  localparam int S   = IN_FRAC_WIDTH - OUT_FRAC_WIDTH;
  localparam int SP  = (S > 0) ? S : 1;
  localparam int SN  = (S < 0) ? -S : 0;
  // One spare bit for the rounding add, or room for the left shift, so nothing wraps.
  localparam int RW  = (S > 0) ? IN_WIDTH + 1 : IN_WIDTH + SN;
  localparam int BUF = (PACK > 1) ? PACK - 1 : 1;
  localparam int CW  = (PACK > 1) ? $clog2(PACK) : 1;

  localparam logic signed [RW-1:0] MAXV = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  function automatic logic [OUT_WIDTH-1:0] cast_lane(input logic signed [IN_WIDTH-1:0] x);
    logic signed [RW-1:0] r;
    r = RW'(x);
    if (S > 0)
      r = (r + (RW'(1) <<< (SP - 1))) >>> SP;
    else if (S < 0)
      r = r <<< SN;
    if (r > MAXV)
      r = MAXV;
    else if (r < MINV)
      r = MINV;
    if (HAS_RELU != 0 && r < 0)
      r = '0;
    return r[OUT_WIDTH-1:0];
  endfunction

  logic [CW-1:0]                          cnt;
  logic [BUF-1:0][IN_SIZE-1:0][OUT_WIDTH-1:0] pack_buf;
  logic [IN_SIZE-1:0][OUT_WIDTH-1:0]      cast_lanes;
  logic [OUT_SIZE-1:0][OUT_WIDTH-1:0]     next_word;
  logic                                   last_beat;
  logic                                   accept;

  assign last_beat     = (cnt == CW'(PACK - 1));
  // Only the closing beat needs the output register free.
  assign data_in_ready = !last_beat || !data_out_valid || data_out_ready;
  assign accept        = data_in_valid && data_in_ready;

  always_comb begin
    cast_lanes = '0;
    for (int j = 0; j < IN_SIZE; j++)
      cast_lanes[j] = cast_lane(data_in[j]);
  end

  always_comb begin
    next_word = '0;
    for (int k = 0; k < PACK - 1; k++)
      for (int j = 0; j < IN_SIZE; j++)
        next_word[k*IN_SIZE+j] = pack_buf[k][j];
    for (int j = 0; j < IN_SIZE; j++)
      next_word[(PACK-1)*IN_SIZE+j] = cast_lanes[j];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      pack_buf       <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      if (data_out_valid && data_out_ready)
        data_out_valid <= 1'b0;
      if (accept) begin
        if (last_beat) begin
          cnt            <= '0;
          data_out       <= next_word;
          data_out_valid <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
          for (int k = 0; k < BUF; k++)
            if (cnt == CW'(k))
              pack_buf[k] <= cast_lanes;
        end
      end
    end
  end

endmodule
